// File: rtl/frame_irq_scheduler.sv
// Frame sequencer: pixel-tick divider, beam counters and RST 1 / RST 2 interrupt scheduling
// with a level request/acknowledge handshake towards the 8080 core.
module frame_irq_scheduler #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned H_TOTAL  = 320,
  parameter int unsigned V_TOTAL  = 262,
  parameter int unsigned MID_LINE = 96,
  parameter int unsigned VBL_LINE = 224
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic                       pix_tick,
  output logic [$clog2(H_TOTAL)-1:0] hcount,
  output logic [$clog2(V_TOTAL)-1:0] vcount,
  input  logic                       irq_enable,
  output logic                       irq_req,
  output logic [7:0]                 irq_vector,
  input  logic                       irq_ack,
  output logic                       irq_overrun
);

  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned HW = $clog2(H_TOTAL);
  localparam int unsigned VW = $clog2(V_TOTAL);

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] MID_V    = VW'(MID_LINE);
  localparam logic [VW-1:0] VBL_V    = VW'(VBL_LINE);
  localparam logic [7:0]    VEC_MID  = 8'hCF;
  localparam logic [7:0]    VEC_VBL  = 8'hD7;

  logic [DW-1:0] r_div;
  logic          r_pend_mid;
  logic          r_pend_vbl;

  logic [DW-1:0] w_div_next;
  logic [VW-1:0] w_v_next;
  logic          w_h_wrap;
  logic          w_mid_ev;
  logic          w_vbl_ev;
  logic          w_ack;
  logic          w_clr_mid;
  logic          w_clr_vbl;

  always_comb begin
    w_div_next = (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
    w_v_next   = (vcount == V_LAST) ? '0 : vcount + 1'b1;
    w_h_wrap   = pix_tick && (hcount == H_LAST);
    // Events fire on the edge that moves the beam onto column 0 of the target line.
    w_mid_ev   = w_h_wrap && (w_v_next == MID_V);
    w_vbl_ev   = w_h_wrap && (w_v_next == VBL_V);
    w_ack      = irq_req && irq_ack;
    w_clr_mid  = w_ack && (irq_vector == VEC_MID);
    w_clr_vbl  = w_ack && (irq_vector == VEC_VBL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div       <= '0;
      pix_tick    <= 1'b0;
      hcount      <= '0;
      vcount      <= '0;
      r_pend_mid  <= 1'b0;
      r_pend_vbl  <= 1'b0;
      irq_req     <= 1'b0;
      irq_vector  <= 8'h00;
      irq_overrun <= 1'b0;
    end else begin
      r_div    <= w_div_next;
      // Registered so that CLK_DIV=1 still shows pix_tick=0 until the first edge after reset.
      pix_tick <= (w_div_next == DIV_LAST);

      if (pix_tick) begin
        if (hcount == H_LAST) begin
          hcount <= '0;
          vcount <= w_v_next;
        end else begin
          hcount <= hcount + 1'b1;
        end
      end

      // An event coinciding with an ack of the same source re-arms it without an overrun.
      r_pend_mid  <= w_mid_ev || (r_pend_mid && !w_clr_mid);
      r_pend_vbl  <= w_vbl_ev || (r_pend_vbl && !w_clr_vbl);
      irq_overrun <= (w_mid_ev && r_pend_mid && !w_clr_mid) ||
                     (w_vbl_ev && r_pend_vbl && !w_clr_vbl);

      if (w_ack) begin
        irq_req <= 1'b0;
      end else begin
        irq_req <= (r_pend_mid || r_pend_vbl) && irq_enable;
      end

      if (!irq_req) begin
        if (r_pend_vbl) begin
          irq_vector <= VEC_VBL;
        end else if (r_pend_mid) begin
          irq_vector <= VEC_MID;
        end
      end
    end
  end

endmodule

// File: tb/tb_frame_irq_scheduler.sv
// Directed bench for frame_irq_scheduler: small frame (CLK_DIV=4, 4x8, MID=2, VBL=6) plus a
// CLK_DIV=1 instance for the divider boundary.
module tb_frame_irq_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       ack = 1'b0;
  logic       pix;
  logic [1:0] h;
  logic [2:0] v;
  logic       req;
  logic [7:0] vec;
  logic       ovr;

  logic       pix1;
  logic [1:0] h1;
  logic [2:0] v1;
  logic       req1;
  logic [7:0] vec1;
  logic       ovr1;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;

  frame_irq_scheduler #(
    .CLK_DIV(4), .H_TOTAL(4), .V_TOTAL(8), .MID_LINE(2), .VBL_LINE(6)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_tick(pix), .hcount(h), .vcount(v),
    .irq_enable(en), .irq_req(req), .irq_vector(vec), .irq_ack(ack), .irq_overrun(ovr)
  );

  frame_irq_scheduler #(
    .CLK_DIV(1), .H_TOTAL(4), .V_TOTAL(8), .MID_LINE(2), .VBL_LINE(6)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .pix_tick(pix1), .hcount(h1), .vcount(v1),
    .irq_enable(1'b0), .irq_req(req1), .irq_vector(vec1), .irq_ack(1'b0), .irq_overrun(ovr1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic goto_cyc(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", req, 0);
    chk("rst_vec", vec, 8'h00);
    chk("rst_ovr", ovr, 0);
    chk("rst_pix", pix, 0);
    chk("rst_pix1", pix1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;
    #1;
    cyc = 0;
    chk("rel_h", h, 0);
    chk("rel_v", v, 0);
    chk("rel_pix", pix, 0);

    // Divider and beam
    goto_cyc(1);  chk("div1_pix", pix1, 1); chk("div1_h", h1, 0);
    goto_cyc(2);  chk("pix_c2", pix, 0);    chk("div1_h2", h1, 1);
    goto_cyc(3);  chk("pix_c3", pix, 1);    chk("h_c3", h, 0);
    goto_cyc(4);  chk("pix_c4", pix, 0);    chk("h_c4", h, 1);  chk("div1_h4", h1, 3);
    goto_cyc(5);  chk("div1_wrap_h", h1, 0); chk("div1_wrap_v", v1, 1);
    chk("div1_req", req1, 0); chk("div1_vec", vec1, 8'h00); chk("div1_ovr", ovr1, 0);
    goto_cyc(7);  chk("pix_c7", pix, 1);
    goto_cyc(8);  chk("h_c8", h, 2);

    // Basic request/ack at MID and VBL
    goto_cyc(32); chk("mid_evt_req", req, 0); chk("mid_evt_v", v, 2); chk("mid_evt_h", h, 0);
    goto_cyc(33); chk("mid_req", req, 1);     chk("mid_vec", vec, 8'hCF);
    ack = 1'b1;
    goto_cyc(34); chk("mid_ack_req", req, 0);
    ack = 1'b0;
    goto_cyc(35); chk("mid_idle_req", req, 0); chk("mid_keep_vec", vec, 8'hCF);
    goto_cyc(96); chk("vbl_evt_req", req, 0);
    goto_cyc(97); chk("vbl_req", req, 1);      chk("vbl_vec", vec, 8'hD7);
    ack = 1'b1;
    goto_cyc(98); chk("vbl_ack_req", req, 0);  chk("vbl_keep_vec", vec, 8'hD7);
    ack = 1'b0;
    goto_cyc(99); chk("vbl_idle_req", req, 0); chk("ovr_none", ovr, 0);
    en = 1'b0;

    goto_cyc(124); chk("beam_end_h", h, 3); chk("beam_end_v", v, 7);
    goto_cyc(128); chk("beam_wrap_h", h, 0); chk("beam_wrap_v", v, 0);

    // Both events while disabled: VBL has priority
    goto_cyc(225); chk("dis_req", req, 0); chk("dis_vec", vec, 8'hD7);
    en = 1'b1;
    goto_cyc(226); chk("en_req", req, 1); chk("en_vec", vec, 8'hD7);
    ack = 1'b1;
    goto_cyc(227); chk("gap_req", req, 0); chk("gap_vec", vec, 8'hD7);
    ack = 1'b0;
    goto_cyc(228); chk("second_req", req, 1); chk("second_vec", vec, 8'hCF);
    ack = 1'b1;
    goto_cyc(229); chk("second_ack", req, 0);
    ack = 1'b0;
    goto_cyc(230); chk("drained_req", req, 0);

    // Unacked for a full frame -> overrun
    goto_cyc(289); chk("f2_req", req, 1); chk("f2_vec", vec, 8'hCF);
    goto_cyc(352); chk("f2_vbl_ovr", ovr, 0);
    goto_cyc(353); chk("hold_vec", vec, 8'hCF); chk("hold_req", req, 1);
    goto_cyc(415); chk("pre_ovr", ovr, 0);
    goto_cyc(416); chk("mid_ovr", ovr, 1);
    goto_cyc(417); chk("mid_ovr_end", ovr, 0); chk("ovr_req", req, 1); chk("ovr_vec", vec, 8'hCF);
    goto_cyc(480); chk("vbl_ovr", ovr, 1);
    goto_cyc(481);
    en = 1'b0;
    goto_cyc(482); chk("drop_req", req, 0); chk("drop_vec", vec, 8'hCF);
    goto_cyc(483); chk("drop_vec_upd", vec, 8'hD7);
    en = 1'b1;
    goto_cyc(484); chk("reen_req", req, 1); chk("reen_vec", vec, 8'hD7);
    ack = 1'b1;
    goto_cyc(485); chk("reen_ack", req, 0);
    ack = 1'b0;
    goto_cyc(486); chk("mid_kept_req", req, 1); chk("mid_kept_vec", vec, 8'hCF);

    // Ack on the exact MID event edge
    goto_cyc(543);
    ack = 1'b1;
    goto_cyc(544); chk("coin_req", req, 0); chk("coin_ovr", ovr, 0);
    ack = 1'b0;
    goto_cyc(545); chk("coin_rereq", req, 1); chk("coin_vec", vec, 8'hCF); chk("coin_ovr2", ovr, 0);

    // Asynchronous reset while requesting
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_req", req, 0);
    chk("arst_vec", vec, 8'h00);
    chk("arst_h", h, 0);
    chk("arst_v", v, 0);
    chk("arst_pix", pix, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    cyc = 0;
    goto_cyc(2);  chk("post_req", req, 0); chk("post_vec", vec, 8'h00);
    goto_cyc(31); chk("post_nopend", req, 0);
    goto_cyc(33); chk("post_mid_req", req, 1); chk("post_mid_vec", vec, 8'hCF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
